arcade_input_mapper: RTL and testbench

- Parametrised replacement for the hand-written per-game input case statement in each arcade top level.
- Merges N player joysticks and maps any joystick bit to any cabinet input bit through a table loaded over ioctl at ROM-load time. ORs in DIP bytes loaded over ioctl.
- Adds coin pulse stretching and autofire gating, neither of which the old hard-coded mapping has.
- Sits between hps_io and the game core; outputs feed the core's input0..inputN ports.

---
 rtl/arcade_input_pkg.sv | 19 +
 rtl/arcade_pulse_stretch.sv | 38 +++
 rtl/arcade_input_mapper.sv | 135 +++++++++++++
 tb/tb_arcade_input_mapper.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arcade_input_pkg.sv
// Shared map-entry layout and default ioctl targets for the arcade input mapper.
package arcade_input_pkg;

  localparam int MAP_EN    = 7;
  localparam int MAP_INV   = 6;
  localparam int MAP_AF    = 5;
  localparam int MAP_SRC_W = 5;

  localparam logic [7:0] DEF_DIP_INDEX = 8'd254;
  localparam logic [7:0] DEF_MAP_INDEX = 8'd2;

  typedef struct packed {
    logic                 en;
    logic                 inv;
    logic                 af;
    logic [MAP_SRC_W-1:0] src;
  } map_entry_t;

endpackage

// File: rtl/arcade_pulse_stretch.sv
// Rising-edge detect feeding a down-counter: output is high for exactly LEN cycles
// per accepted edge; edges arriving while the counter runs are dropped.
module arcade_pulse_stretch #(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] LEN   = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic pulse
);

  logic             prev_q, prev_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    prev_d = in;
    cnt_d  = cnt_q;
    if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end else if (in && !prev_q) begin
      cnt_d = LEN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pulse = (cnt_q != '0);

endmodule

// File: rtl/arcade_input_mapper.sv
// Table-driven joystick-to-cabinet input mapper with DIP overlay, coin stretching
// and autofire gating; map and DIP bytes arrive over the hps ioctl download port.
module arcade_input_mapper
  import arcade_input_pkg::*;
#(
  parameter int          NUM_PLAYERS   = 2,
  parameter int          JOY_W         = 32,
  parameter int          NUM_IN_BYTES  = 3,
  parameter int          NUM_DIP_BYTES = 8,
  parameter logic [7:0]  DIP_INDEX     = DEF_DIP_INDEX,
  parameter logic [7:0]  MAP_INDEX     = DEF_MAP_INDEX,
  parameter int          COIN_BIT      = 11,
  parameter logic [15:0] COIN_PULSE    = 16'd24000,
  parameter logic [19:0] AF_DIV        = 20'd400000
) (
  input  logic                         clk_sys,
  input  logic                         reset,
  input  logic [NUM_PLAYERS*JOY_W-1:0] joy,
  input  logic                         ioctl_download,
  input  logic [7:0]                   ioctl_index,
  input  logic                         ioctl_wr,
  input  logic [24:0]                  ioctl_addr,
  input  logic [7:0]                   ioctl_dout,
  input  logic                         autofire_en,
  output logic [NUM_IN_BYTES*8-1:0]    in_bytes,
  output logic                         map_busy,
  output logic [NUM_DIP_BYTES*8-1:0]   dip
);

  localparam int NUM_MAP  = NUM_IN_BYTES * 8;
  localparam int SRC_N    = 1 << MAP_SRC_W;
  localparam int SRC_USED = (JOY_W < SRC_N) ? JOY_W : SRC_N;

  logic [NUM_MAP*8-1:0]       map_q, map_d;
  logic [NUM_DIP_BYTES*8-1:0] dip_q, dip_d;
  logic                       map_busy_q, map_busy_d;
  logic [JOY_W-1:0]           merged_q, merged_d;
  logic [19:0]                af_div_q, af_div_d;
  logic                       af_phase_q, af_phase_d;
  logic [NUM_MAP-1:0]         in_bytes_q, in_bytes_d;
  logic                       coin_s;
  logic [SRC_N-1:0]           src_vec;
  map_entry_t                 entry;
  logic                       src_bit;
  logic                       mapped_bit;

  // ioctl is a write strobe with no back-pressure: a byte is taken on every cycle
  // ioctl_wr is high, addressed by ioctl_index/ioctl_addr; out-of-range addresses drop.
  always_comb begin
    map_d      = map_q;
    dip_d      = dip_q;
    map_busy_d = ioctl_download && (ioctl_index == MAP_INDEX);
    if (ioctl_wr && (ioctl_index == DIP_INDEX)) begin
      for (int i = 0; i < NUM_DIP_BYTES; i++) begin
        if (ioctl_addr == 25'(i)) dip_d[i*8 +: 8] = ioctl_dout;
      end
    end
    if (ioctl_wr && (ioctl_index == MAP_INDEX)) begin
      for (int k = 0; k < NUM_MAP; k++) begin
        if (ioctl_addr == 25'(k)) map_d[k*8 +: 8] = ioctl_dout;
      end
    end
  end

  always_comb begin
    merged_d = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      merged_d = merged_d | joy[p*JOY_W +: JOY_W];
    end
  end

  always_comb begin
    af_div_d   = af_div_q + 20'd1;
    af_phase_d = af_phase_q;
    if (af_div_q == AF_DIV - 20'd1) begin
      af_div_d   = '0;
      af_phase_d = ~af_phase_q;
    end
  end

  // The stretcher's counter acts as the stage-1 register for the coin bit.
  arcade_pulse_stretch #(
    .WIDTH (16),
    .LEN   (COIN_PULSE)
  ) u_coin (
    .clk   (clk_sys),
    .rst   (reset),
    .in    (merged_q[COIN_BIT]),
    .pulse (coin_s)
  );

  always_comb begin
    src_vec    = '0;
    entry      = '0;
    src_bit    = 1'b0;
    mapped_bit = 1'b0;
    in_bytes_d = '0;
    for (int j = 0; j < SRC_USED; j++) begin
      src_vec[j] = merged_q[j];
    end
    src_vec[COIN_BIT] = coin_s;
    for (int k = 0; k < NUM_MAP; k++) begin
      entry   = map_entry_t'(map_q[k*8 +: 8]);
      src_bit = src_vec[entry.src];
      if (entry.af) src_bit = src_bit & (af_phase_q | ~autofire_en);
      mapped_bit    = entry.en & (src_bit ^ entry.inv) & ~map_busy_q;
      in_bytes_d[k] = dip_q[k] | mapped_bit;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      map_q      <= '0;
      dip_q      <= '0;
      map_busy_q <= 1'b0;
      merged_q   <= '0;
      af_div_q   <= '0;
      af_phase_q <= 1'b0;
      in_bytes_q <= '0;
    end else begin
      map_q      <= map_d;
      dip_q      <= dip_d;
      map_busy_q <= map_busy_d;
      merged_q   <= merged_d;
      af_div_q   <= af_div_d;
      af_phase_q <= af_phase_d;
      in_bytes_q <= in_bytes_d;
    end
  end

  assign in_bytes = in_bytes_q;
  assign map_busy = map_busy_q;
  assign dip      = dip_q;

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Cycle-level scoreboard bench for arcade_input_mapper with directed checks on mapping,
// coin stretching, autofire, download busy, range limits and asynchronous reset.
module tb_arcade_input_mapper;

  localparam int         NP     = 2;
  localparam int         JW     = 32;
  localparam int         NIB    = 3;
  localparam int         NDB    = 8;
  localparam int         NMAP   = NIB * 8;
  localparam int         COIN_B = 11;
  localparam int         PULSE  = 5;
  localparam int         AFD    = 4;
  localparam logic [7:0] DIPI   = 8'd254;
  localparam logic [7:0] MAPI   = 8'd2;

  logic               clk_sys;
  logic               reset;
  logic [NP*JW-1:0]   joy;
  logic               ioctl_download;
  logic [7:0]         ioctl_index;
  logic               ioctl_wr;
  logic [24:0]        ioctl_addr;
  logic [7:0]         ioctl_dout;
  logic               autofire_en;
  logic [NIB*8-1:0]   in_bytes;
  logic               map_busy;
  logic [NDB*8-1:0]   dip;

  // clock / reset
  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  arcade_input_mapper #(
    .NUM_PLAYERS   (NP),
    .JOY_W         (JW),
    .NUM_IN_BYTES  (NIB),
    .NUM_DIP_BYTES (NDB),
    .DIP_INDEX     (DIPI),
    .MAP_INDEX     (MAPI),
    .COIN_BIT      (COIN_B),
    .COIN_PULSE    (16'(PULSE)),
    .AF_DIV        (20'(AFD))
  ) dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .joy            (joy),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .autofire_en    (autofire_en),
    .in_bytes       (in_bytes),
    .map_busy       (map_busy),
    .dip            (dip)
  );

  // scoreboard and reference state
  logic [NIB*8-1:0] exp_q[$];
  int               n_cmp;
  int               n_bad;

  logic [7:0]       m_map[NMAP];
  logic [7:0]       m_dip[NDB];
  logic             m_busy;
  logic [JW-1:0]    m_merged;
  logic             m_prev;
  int               m_cnt;
  int               m_div;
  logic             m_phase;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NMAP; k++) m_map[k] = 8'h00;
    for (int i = 0; i < NDB; i++) m_dip[i] = 8'h00;
    m_busy   = 1'b0;
    m_merged = '0;
    m_prev   = 1'b0;
    m_cnt    = 0;
    m_div    = 0;
    m_phase  = 1'b0;
  endtask

  function automatic logic [NDB*8-1:0] model_dip();
    logic [NDB*8-1:0] r;
    for (int i = 0; i < NDB; i++) r[i*8 +: 8] = m_dip[i];
    return r;
  endfunction

  // Output the DUT will present after the coming edge, from state after the last edge.
  function automatic logic [NIB*8-1:0] model_out();
    logic [JW-1:0]    eff;
    logic [NIB*8-1:0] r;
    logic [7:0]       e;
    logic             s;
    eff         = m_merged;
    eff[COIN_B] = (m_cnt != 0);
    for (int k = 0; k < NMAP; k++) begin
      e = m_map[k];
      s = eff[e[4:0]];
      if (e[5]) s = s & (m_phase | ~autofire_en);
      r[k] = m_dip[k/8][k%8] | (~m_busy & e[7] & (s ^ e[6]));
    end
    return r;
  endfunction

  task automatic model_edge();
    if (m_cnt != 0) m_cnt = m_cnt - 1;
    else if (m_merged[COIN_B] && !m_prev) m_cnt = PULSE;
    m_prev   = m_merged[COIN_B];
    m_merged = joy[JW-1:0] | joy[2*JW-1:JW];
    if (ioctl_wr && ioctl_index == DIPI && ioctl_addr < NDB) m_dip[int'(ioctl_addr)] = ioctl_dout;
    if (ioctl_wr && ioctl_index == MAPI && ioctl_addr < NMAP) m_map[int'(ioctl_addr)] = ioctl_dout;
    m_busy = ioctl_download && (ioctl_index == MAPI);
    if (m_div == AFD - 1) begin
      m_div   = 0;
      m_phase = ~m_phase;
    end else begin
      m_div = m_div + 1;
    end
  endtask

  // One clock: push expectation, advance model, clock, pop and compare.
  task automatic step();
    exp_q.push_back(model_out());
    model_edge();
    @(posedge clk_sys);
    #1;
    check("in_bytes", in_bytes, exp_q.pop_front());
    check("map_busy", map_busy, m_busy);
    check("dip", dip, model_dip());
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // driver
  task automatic wr_byte(input logic [7:0] idx, input int addr, input logic [7:0] data);
    ioctl_download = 1'b1;
    ioctl_index    = idx;
    ioctl_wr       = 1'b1;
    ioctl_addr     = 25'(addr);
    ioctl_dout     = data;
    step();
    ioctl_wr       = 1'b0;
    ioctl_download = 1'b0;
  endtask

  task automatic count_high(input int n, input int bit_i, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (in_bytes[bit_i]) cnt++;
    end
  endtask

  int   cnt;
  int   viol;
  logic s_af[16];

  initial begin
    n_cmp          = 0;
    n_bad          = 0;
    reset          = 1'b1;
    joy            = '0;
    ioctl_download = 1'b0;
    ioctl_index    = 8'h00;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = 8'h00;
    autofire_en    = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_sys);
    #1;
    check("rst_in_bytes", in_bytes, 0);
    check("rst_map_busy", map_busy, 0);
    check("rst_dip", dip, 0);
    reset = 1'b0;

    // basic mapping with DIP overlay, player 1 source
    wr_byte(MAPI, 0, 8'h84);
    wr_byte(DIPI, 0, 8'h10);
    steps(3);
    joy[JW+4] = 1'b1;
    step();
    check("joy4_lat1", in_bytes[7:0], 8'h10);
    step();
    check("joy4_p1", in_bytes[7:0], 8'h11);
    joy = '0;
    steps(2);
    check("joy4_clear", in_bytes[7:0], 8'h10);

    // invert, and invert while disabled
    wr_byte(MAPI, 1, 8'hC3);
    wr_byte(MAPI, 2, 8'h43);
    steps(3);
    check("inv_idle", in_bytes[7:0], 8'h12);
    joy[3] = 1'b1;
    steps(2);
    check("inv_up", in_bytes[7:0], 8'h10);
    joy = '0;
    steps(2);

    // coin stretching: long hold, retrigger during pulse, fresh press
    wr_byte(MAPI, 12, 8'h8B);
    steps(3);
    joy[COIN_B] = 1'b1;
    count_high(100, 12, cnt);
    check("coin_hold", cnt, PULSE);
    joy = '0;
    steps(3);
    joy[COIN_B] = 1'b1;
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (in_bytes[12]) cnt++;
    end
    joy = '0;
    step();
    if (in_bytes[12]) cnt++;
    joy[JW+COIN_B] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (in_bytes[12]) cnt++;
    end
    check("coin_retrig", cnt, PULSE);
    joy = '0;
    steps(3);
    joy[COIN_B] = 1'b1;
    count_high(20, 12, cnt);
    check("coin_repress", cnt, PULSE);
    joy = '0;
    steps(3);

    // autofire
    wr_byte(MAPI, 0, 8'hA4);
    autofire_en = 1'b1;
    joy[4]      = 1'b1;
    steps(3);
    for (int i = 0; i < 16; i++) begin
      step();
      s_af[i] = in_bytes[0];
    end
    viol = 0;
    for (int i = 0; i < 12; i++) if (s_af[i+4] == s_af[i]) viol++;
    check("af_half_period", viol, 0);
    autofire_en = 1'b0;
    steps(2);
    count_high(8, 0, cnt);
    check("af_off_steady", cnt, 8);

    // download busy masks mapping
    ioctl_download = 1'b1;
    ioctl_index    = MAPI;
    steps(2);
    check("busy_high", map_busy, 1);
    check("busy_dip_only", in_bytes, 24'h000010);
    ioctl_download = 1'b0;
    step();
    check("busy_drop_dip", in_bytes, 24'h000010);
    step();
    check("busy_resume", in_bytes, 24'h000013);

    // out-of-range writes are ignored
    wr_byte(DIPI, NDB, 8'hFF);
    wr_byte(MAPI, NMAP, 8'hFF);
    steps(3);
    check("oor_dip", dip, 64'h10);
    check("oor_map", in_bytes, 24'h000013);

    // DIP write and output update in the same cycle; top DIP address
    wr_byte(DIPI, 1, 8'h5A);
    check("dip_old_val", in_bytes[15:8], 8'h00);
    step();
    check("dip_new_val", in_bytes[15:8], 8'h5A);
    wr_byte(DIPI, NDB - 1, 8'hA5);
    step();
    check("dip_top_addr", dip[63:56], 8'hA5);

    // reset in the middle of a map download
    ioctl_download = 1'b1;
    ioctl_index    = MAPI;
    ioctl_wr       = 1'b1;
    ioctl_addr     = 25'd5;
    ioctl_dout     = 8'h84;
    step();
    reset = 1'b1;
    #1;
    check("async_in_bytes", in_bytes, 0);
    check("async_map_busy", map_busy, 0);
    check("async_dip", dip, 0);
    model_reset();
    @(posedge clk_sys);
    #1;
    reset          = 1'b0;
    ioctl_wr       = 1'b0;
    ioctl_download = 1'b0;
    steps(3);
    check("map_cleared", in_bytes, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
